// File: rtl/logic_unit_pkg.sv
// Shared opcode definitions for the pipelined logic unit and its combinational core.
package logic_unit_pkg;

   localparam int OP_W = 3;

   // Bit 0 and bit 1 keep their legacy AluOp0/AluOp1 meaning; bit 2 selects the extended set
   typedef enum logic [OP_W-1:0] {
      OP_AND    = 3'b000,
      OP_OR     = 3'b001,
      OP_XOR    = 3'b010,
      OP_NOR    = 3'b011,
      OP_NAND   = 3'b100,
      OP_ANDN   = 3'b101,
      OP_XNOR   = 3'b110,
      OP_PASS_A = 3'b111
   } opcode_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational WIDTH-bit bitwise operation decode and compute, with a zero flag on the result.
module logic_unit_core
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   // Every operation is purely bitwise, so no carries or width extension are involved
   always_comb begin
      result = '0;
      case (opcode_e'(op))
         OP_AND:    result = a & b;
         OP_OR:     result = a | b;
         OP_XOR:    result = a ^ b;
         OP_NOR:    result = ~(a | b);
         OP_NAND:   result = ~(a & b);
         OP_ANDN:   result = a & ~b;
         OP_XNOR:   result = ~(a ^ b);
         OP_PASS_A: result = a;
         default:   result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/pipe_logic_unit.sv
// Two-stage pipelined logic unit with valid/ready handshakes and a completed-operation counter.
// Optional out_parity output is enabled by defining LOGIC_UNIT_PARITY_EN.
module pipe_logic_unit
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [OP_W-1:0]  in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
`ifdef LOGIC_UNIT_PARITY_EN
   output logic             out_parity,
`endif
   output logic [CNT_W-1:0] op_count
);

   logic             s1Valid;
   logic [WIDTH-1:0] s1A;
   logic [WIDTH-1:0] s1B;
   logic [OP_W-1:0]  s1Op;

   logic             s2Adv;
   logic             s1Adv;
   logic             accept;
   logic             drain;
   logic [WIDTH-1:0] coreResult;
   logic             coreZero;

   // Ready depends only on pipeline state and out_ready, never on in_valid
   assign s2Adv    = !out_valid || out_ready;
   assign s1Adv    = !s1Valid || s2Adv;
   assign in_ready = s1Adv;
   assign accept   = in_valid && s1Adv;
   assign drain    = out_valid && out_ready;

   logic_unit_core #(
      .WIDTH (WIDTH)
   ) core (
      .a      (s1A),
      .b      (s1B),
      .op     (s1Op),
      .result (coreResult),
      .zero   (coreZero)
   );

   // Stage 1 captures operands; it empties when its contents move on and nothing new arrives
   always_ff @(posedge clk) begin
      if (rst) begin
         s1Valid <= 1'b0;
         s1A     <= '0;
         s1B     <= '0;
         s1Op    <= '0;
      end else if (accept) begin
         s1Valid <= 1'b1;
         s1A     <= in_a;
         s1B     <= in_b;
         s1Op    <= in_op;
      end else if (s2Adv) begin
         s1Valid <= 1'b0;
      end
   end

   // Stage 2 holds the registered result; it only changes when the consumer frees it
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_zero   <= 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
         out_parity <= 1'b0;
`endif
      end else if (s2Adv) begin
         out_valid <= s1Valid;
         if (s1Valid) begin
            out_result <= coreResult;
            out_zero   <= coreZero;
`ifdef LOGIC_UNIT_PARITY_EN
            out_parity <= ^coreResult;
`endif
         end
      end
   end

   // Counts results taken downstream; wraps silently at the top of its range
   always_ff @(posedge clk) begin
      if (rst) begin
         op_count <= '0;
      end else if (drain) begin
         op_count <= op_count + 1'b1;
      end
   end

endmodule
